bus_rr_arbit: RTL



---
 rtl/bus_rr_arbit.sv | 74 +++++++
 1 files changed

// File: rtl/bus_rr_arbit.sv
// Four-master round-robin bus arbiter with a hold limit against starvation.
// Exactly one grant is always high; an idle bus stays parked on the last owner.
module bus_rr_arbit #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] M_request,
  output logic [3:0] M_grant,
  output logic [1:0] grant_id,
  output logic       grant_changed
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       owner_q, owner_d;
  logic [1:0]       rr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       others;
  logic             owner_req;
  logic             switch_en;
  logic             found;

  always_comb begin
    others          = M_request;
    others[owner_q] = 1'b0;
    owner_req       = M_request[owner_q];
  end

  // First requester after the owner in circular order (owner+1 .. owner+3).
  always_comb begin
    rr_next = owner_q;
    found   = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (!found && others[owner_q + 2'(k)]) begin
        rr_next = owner_q + 2'(k);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    switch_en = 1'b0;
    if (others != 4'b0000) begin
      if (!owner_req || cnt_q == HoldLast) begin
        switch_en = 1'b1;
        owner_d   = rr_next;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q       <= 2'd0;
      cnt_q         <= '0;
      M_grant       <= 4'b0001;
      grant_changed <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      M_grant       <= 4'b0001 << owner_d;
      grant_changed <= switch_en;
    end
  end

  assign grant_id = owner_q;

endmodule
